alu_issue_unit: RTL

Sequencing front end for the single-cycle ALU. It accepts one decoded operation per valid/ready request, translates the RISC-V `alu_op`/`funct3`/`funct7[5]` fields into the 3-bit ALU select code, and drives the ALU operand ports for exactly one cycle. It then captures `alu_result` and `zero` into a response register held under a valid/ready handshake. It sits between the decode stage and the ALU, on the initiator side of the ALU's operand/select interface.

---
 rtl/alu_issue_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// Issue front end for the single-cycle ALU: decodes alu_op/funct3/funct7[5] into an
// ALU select, drives the ALU for one cycle, and holds the result under valid/ready.
module alu_issue_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_alu_op_i,
  input  logic [2:0]      req_funct3_i,
  input  logic            req_funct7b5_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [XLEN-1:0] req_imm_i,
  output logic [XLEN-1:0] alu_in_a_o,
  output logic [XLEN-1:0] alu_in_b_o,
  output logic [2:0]      alu_sel_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o,
  output logic            rsp_zero_o,
  output logic            rsp_illegal_o
);

  // state | meaning
  // IDLE  | ready for a request, ALU ports held at 0
  // EXEC  | registered operands/select on the ALU ports for one cycle
  // DONE  | response valid and held until rsp_ready_i
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;
  localparam logic [2:0] SEL_SLT = 3'b101;
  localparam logic [2:0] SEL_SLL = 3'b110;
  localparam logic [2:0] SEL_SRL = 3'b111;

  localparam logic [1:0] OP_MEM  = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_RTYP = 2'b10;
  localparam logic [1:0] OP_ITYP = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [2:0]      sel_q, sel_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_illegal_q, rsp_illegal_d;

  logic [2:0]      dec_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_src_b;
  logic [XLEN-1:0] dec_b;
  logic            exec_live;

  always_comb begin
    dec_sel     = SEL_ADD;
    dec_illegal = 1'b0;
    case (req_alu_op_i)
      OP_MEM: dec_sel = SEL_ADD;
      OP_BR:  dec_sel = SEL_SUB;
      default: begin
        case (req_funct3_i)
          3'b000: dec_sel = (req_alu_op_i == OP_RTYP && req_funct7b5_i) ? SEL_SUB : SEL_ADD;
          3'b001: dec_sel = SEL_SLL;
          3'b010: dec_sel = SEL_SLT;
          3'b011: dec_illegal = 1'b1;
          3'b100: dec_sel = SEL_XOR;
          3'b101: begin
            if (req_funct7b5_i) dec_illegal = 1'b1;
            else                dec_sel     = SEL_SRL;
          end
          3'b110: dec_sel = SEL_OR;
          default: dec_sel = SEL_AND;
        endcase
      end
    endcase
  end

  // The ALU shifts by its full operand B, so trim to a 5-bit shift amount here.
  always_comb begin
    dec_src_b = (req_alu_op_i == OP_MEM || req_alu_op_i == OP_ITYP) ? req_imm_i : req_rs2_i;
    if (dec_sel == SEL_SLL || dec_sel == SEL_SRL)
      dec_b = {{(XLEN-5){1'b0}}, dec_src_b[4:0]};
    else
      dec_b = dec_src_b;
  end

  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    sel_d         = sel_q;
    illegal_d     = illegal_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_a_d    = req_rs1_i;
          op_b_d    = dec_b;
          sel_d     = dec_sel;
          illegal_d = dec_illegal;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d  = illegal_q ? '0 : alu_result_i;
        rsp_zero_d    = !illegal_q && alu_zero_i;
        rsp_illegal_d = illegal_q;
        state_d       = DONE;
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sel_q         <= SEL_ADD;
      illegal_q     <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      sel_q         <= sel_d;
      illegal_q     <= illegal_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // Illegal requests still spend their EXEC cycle, but with the ALU ports parked at 0.
  assign exec_live     = (state_q == EXEC) && !illegal_q;
  assign alu_in_a_o    = exec_live ? op_a_q : '0;
  assign alu_in_b_o    = exec_live ? op_b_q : '0;
  assign alu_sel_o     = exec_live ? sel_q  : SEL_ADD;

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == DONE);
  assign rsp_result_o  = rsp_result_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule
